// File: rtl/auth_seq_blk.sv
// auth_seq_blk: rider-authentication controller for the power path.
// A start byte followed by the full passcode raises pwr_up. A stop byte plus
// a continuously high rider_off lowers it again. MAX_FAILS consecutive bad
// attempts lock the block out for LOCK_CYCLES cycles.
// Optional macro AUTH_TIMEOUT_EN adds an inter-byte timeout (BYTE_TMO cycles)
// while a passcode is being entered; a timeout counts as a failed attempt.
module auth_seq_blk #(
  parameter int unsigned           CODE_LEN    = 4,
  parameter logic [8*CODE_LEN-1:0] CODE        = 32'h3132_3334,
  parameter logic [7:0]            START_BYTE  = 8'h47,
  parameter logic [7:0]            STOP_BYTE   = 8'h53,
  parameter int unsigned           MAX_FAILS   = 3,
  parameter int unsigned           LOCK_CYCLES = 50_000_000,
  parameter int unsigned           OFF_CYCLES  = 1_000_000
`ifdef AUTH_TIMEOUT_EN
  ,
  parameter int unsigned           BYTE_TMO    = 25_000_000
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       rx_data,
  input  logic                             rdy,
  output logic                             clr_rdy,
  input  logic                             rider_off,
  output logic                             pwr_up,
  output logic                             locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned IDX_W  = (CODE_LEN    > 1) ? $clog2(CODE_LEN)    : 1;
  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int unsigned OFF_W  = (OFF_CYCLES  > 1) ? $clog2(OFF_CYCLES)  : 1;
`ifdef AUTH_TIMEOUT_EN
  localparam int unsigned TMO_W  = (BYTE_TMO    > 1) ? $clog2(BYTE_TMO)    : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CODE      = 3'd1,
    S_ENABLED   = 3'd2,
    S_STOP_PEND = 3'd3,
    S_LOCKOUT   = 3'd4
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [LOCK_W-1:0] lock_cnt;
  logic [OFF_W-1:0]  off_cnt;
  logic [7:0]        exp_byte;
  logic              code_fail_c;
`ifdef AUTH_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_cnt;
`endif

  // Every presented byte is consumed in the cycle it appears.
  assign clr_rdy = rdy;

  // Passcode byte expected at the current position; first byte sits in the MSBs.
  assign exp_byte = 8'(CODE >> (8 * (CODE_LEN - 1 - 32'(idx))));

  // An attempt fails on a wrong byte (or, when enabled, on inter-byte timeout).
  always_comb begin
    code_fail_c = 1'b0;
    if (state == S_CODE) begin
      if (rdy) begin
        code_fail_c = (rx_data != exp_byte);
      end
`ifdef AUTH_TIMEOUT_EN
      else begin
        code_fail_c = (tmo_cnt == TMO_W'(BYTE_TMO - 1));
      end
`endif
    end
  end

  // Authentication state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pwr_up   <= 1'b0;
      locked   <= 1'b0;
      fail_cnt <= '0;
      idx      <= '0;
      lock_cnt <= '0;
      off_cnt  <= '0;
`ifdef AUTH_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rdy && (rx_data == START_BYTE)) begin
            idx   <= '0;
`ifdef AUTH_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state <= S_CODE;
          end
        end

        S_CODE: begin
          if (code_fail_c) begin
            if ((32'(fail_cnt) + 32'd1) == MAX_FAILS) begin
              fail_cnt <= FAIL_W'(MAX_FAILS);
              locked   <= 1'b1;
              lock_cnt <= '0;
              state    <= S_LOCKOUT;
            end else begin
              fail_cnt <= fail_cnt + FAIL_W'(1);
              state    <= S_IDLE;
            end
          end else if (rdy) begin
`ifdef AUTH_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            if (32'(idx) == (CODE_LEN - 1)) begin
              pwr_up   <= 1'b1;
              fail_cnt <= '0;
              state    <= S_ENABLED;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
`ifdef AUTH_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end

        S_ENABLED: begin
          if (rdy && (rx_data == STOP_BYTE)) begin
            off_cnt <= '0;
            state   <= S_STOP_PEND;
          end
        end

        S_STOP_PEND: begin
          // A start byte cancels the stop request, even on the terminal cycle.
          if (rdy && (rx_data == START_BYTE)) begin
            state <= S_ENABLED;
          end else if (rider_off) begin
            if (off_cnt == OFF_W'(OFF_CYCLES - 1)) begin
              pwr_up <= 1'b0;
              state  <= S_IDLE;
            end else begin
              off_cnt <= off_cnt + OFF_W'(1);
            end
          end else begin
            off_cnt <= '0;
          end
        end

        S_LOCKOUT: begin
          if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
            locked   <= 1'b0;
            fail_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
          end
        end

        default: begin
          pwr_up <= 1'b0;
          locked <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_auth_seq_blk.sv
// Scoreboard bench for auth_seq_blk: a cycle-level behavioural model pushes
// expected outputs; a monitor on the falling edge pops and compares them.
module tb_auth_seq_blk;

  localparam int unsigned CODE_LEN    = 2;
  localparam logic [15:0] TB_CODE     = 16'h3132;
  localparam int unsigned MAX_FAILS   = 2;
  localparam int unsigned LOCK_CYCLES = 8;
  localparam int unsigned OFF_CYCLES  = 4;
  localparam int unsigned BYTE_TMO    = 10;
  localparam int unsigned FC_W        = $clog2(MAX_FAILS + 1);
  localparam logic [7:0]  B_START     = 8'h47;
  localparam logic [7:0]  B_STOP      = 8'h53;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      rx_data = 8'h00;
  logic            rdy = 1'b0;
  logic            clr_rdy;
  logic            rider_off = 1'b0;
  logic            pwr_up;
  logic            locked;
  logic [FC_W-1:0] fail_cnt;

  always #5 clk = ~clk;

  auth_seq_blk #(
    .CODE_LEN    (CODE_LEN),
    .CODE        (TB_CODE),
    .START_BYTE  (B_START),
    .STOP_BYTE   (B_STOP),
    .MAX_FAILS   (MAX_FAILS),
    .LOCK_CYCLES (LOCK_CYCLES),
    .OFF_CYCLES  (OFF_CYCLES)
`ifdef AUTH_TIMEOUT_EN
    ,
    .BYTE_TMO    (BYTE_TMO)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rdy       (rdy),
    .clr_rdy   (clr_rdy),
    .rider_off (rider_off),
    .pwr_up    (pwr_up),
    .locked    (locked),
    .fail_cnt  (fail_cnt)
  );

  typedef struct {
    bit pwr;
    bit lck;
    int fc;
    bit clr;
  } exp_t;

  exp_t exp_q[$];
  bit   started = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: rider status in plain terms.
  logic [7:0] code_b[CODE_LEN];
  bit m_pwr, m_locked, in_attempt, stop_req;
  int m_fails, matched, off_run, lock_left, silent;

  task automatic fail_attempt();
    in_attempt = 1'b0;
    m_fails++;
    if (m_fails == int'(MAX_FAILS)) begin
      m_locked  = 1'b1;
      lock_left = int'(LOCK_CYCLES);
    end
  endtask

  task automatic model_step(input bit r, input logic [7:0] d, input bit off, input bit rs);
    if (rs) begin
      m_pwr = 0; m_locked = 0; in_attempt = 0; stop_req = 0;
      m_fails = 0; matched = 0; off_run = 0; lock_left = 0; silent = 0;
    end else if (m_locked) begin
      lock_left--;
      if (lock_left == 0) begin
        m_locked = 1'b0;
        m_fails  = 0;
      end
    end else if (m_pwr && stop_req) begin
      if (r && d == B_START) stop_req = 1'b0;
      else if (off) begin
        off_run++;
        if (off_run == int'(OFF_CYCLES)) begin
          m_pwr = 1'b0;
          stop_req = 1'b0;
        end
      end else off_run = 0;
    end else if (m_pwr) begin
      if (r && d == B_STOP) begin
        stop_req = 1'b1;
        off_run  = 0;
      end
    end else if (in_attempt) begin
      if (r) begin
        silent = 0;
        if (d == code_b[matched]) begin
          matched++;
          if (matched == int'(CODE_LEN)) begin
            in_attempt = 1'b0;
            m_pwr      = 1'b1;
            m_fails    = 0;
          end
        end else fail_attempt();
      end else begin
`ifdef AUTH_TIMEOUT_EN
        silent++;
        if (silent == int'(BYTE_TMO)) fail_attempt();
`endif
      end
    end else if (r && d == B_START) begin
      in_attempt = 1'b1;
      matched    = 0;
      silent     = 0;
    end
  endtask

  // One cycle: model consumes the inputs present at this edge, then new inputs are driven.
  task automatic cyc(input bit r, input logic [7:0] d, input bit off, input bit rs);
    exp_t e;
    @(posedge clk);
    model_step(rdy, rx_data, rider_off, rst);
    #1;
    rst = rs; rdy = r; rx_data = d; rider_off = off;
    e.pwr = m_pwr; e.lck = m_locked; e.fc = m_fails; e.clr = r;
    exp_q.push_back(e);
    started = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit off);
    cyc(1'b1, b, off, 1'b0);
  endtask

  task automatic idle(input int n, input bit off);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, off, 1'b0);
  endtask

  function automatic void check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
    end
  endfunction

  // Monitor: compares DUT outputs against the oldest expectation each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard_empty: got 0 entries, want 1 at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pwr_up",   8'(pwr_up),   8'(e.pwr));
          check("locked",   8'(locked),   8'(e.lck));
          check("fail_cnt", 8'(fail_cnt), 8'(e.fc));
          check("clr_rdy",  8'(clr_rdy),  8'(e.clr));
        end
      end
    end
  end

  initial begin
    logic [15:0] cv;
    bit off_r;
    cv = TB_CODE;
    for (int i = 0; i < int'(CODE_LEN); i++) code_b[i] = cv[8*(int'(CODE_LEN)-1-i) +: 8];

    // Reset, then a good passcode.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2, 1'b0);
    send(8'h47, 0); send(8'h31, 0); idle(1, 0); send(8'h32, 0); idle(3, 0);
    // Stop with rider already off.
    send(8'h53, 1); idle(8, 1); idle(2, 0);
    // Bad attempts into lockout; a good code during lockout is ignored.
    send(8'h47, 0); send(8'h31, 0); send(8'h39, 0); idle(2, 0);
    send(8'h47, 0); send(8'h35, 0); idle(1, 0);
    send(8'h47, 0); send(8'h31, 0); send(8'h32, 0); idle(8, 0);
    send(8'h47, 0); send(8'h31, 0); send(8'h32, 0); idle(2, 0);
    // Stop with rider_off glitching low once.
    send(8'h53, 0);
    cyc(0, 8'h00, 1, 0); cyc(0, 8'h00, 1, 0); cyc(0, 8'h00, 0, 0);
    idle(6, 1); idle(2, 0);
    // Stop cancelled by a start byte; rider_off alone then must not power down.
    send(8'h47, 0); send(8'h31, 0); send(8'h32, 0); idle(1, 0);
    send(8'h53, 0); idle(1, 1); send(8'h47, 1); idle(10, 1); idle(1, 0);
    // Stop cancelled on the terminal-count cycle.
    send(8'h53, 1); idle(3, 1); send(8'h47, 1); idle(6, 1);
    // Reset while powered.
    cyc(0, 8'h00, 0, 1); idle(3, 0);
    // Stalled attempt (times out only when the timeout is built in).
    send(8'h47, 0); send(8'h31, 0); idle(14, 0);
    cyc(0, 8'h00, 0, 1); idle(2, 0);

    // Randomized traffic.
    off_r = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      int p;
      logic [7:0] b;
      p = int'($urandom_range(0, 199));
      if ($urandom_range(0, 99) < 15) off_r = ~off_r;
      if (p < 2) cyc(0, 8'h00, off_r, 1);
      else if (p < 10) begin
        send(8'h47, off_r); send(8'h31, off_r); send(8'h32, off_r);
      end else if (p < 90) begin
        case ($urandom_range(0, 5))
          0: b = 8'h47;
          1: b = 8'h31;
          2: b = 8'h32;
          3: b = 8'h53;
          default: b = 8'($urandom);
        endcase
        send(b, off_r);
      end else cyc(0, 8'h00, off_r, 0);
    end
    idle(2, 0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
